two_dncnt: RTL and testbench

Two-digit BCD down counter / countdown timer, the decrementing counterpart of the team's two-digit BCD up counter. The block loads a preset value 00–99, counts down one step per enabled tick with a ones-to-tens borrow chain, and stops at 00. A start/pause control FSM sits in front of the digit datapath. Output digits feed the seven-segment display path; `done` drives the alarm/LED logic.

---
 rtl/two_dncnt.sv | 171 +++++++++++++++++
 tb/tb_two_dncnt.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/two_dncnt.sv
// -----------------------------------------------------------------------------
// two_dncnt : two-digit BCD countdown timer.
//
// This block loads a preset value from 00 to 99. It counts down one step on
// each enabled tick, using a borrow chain from the ones digit to the tens
// digit, and stops at 00. A start/pause FSM sits in front of the digit
// datapath. The out0/out1 digits drive the seven-segment path. The done
// output drives the alarm logic.
//
// Optional feature, controlled by the macro AUTO_RELOAD_EN:
//   Defined   - each load also captures its value into a reload register.
//               In RUN, the tick that would reach 00 reloads that value and
//               stays in RUN, and done pulses high for one cycle. If the
//               reload value is 00, the block behaves as in the default build.
//   Undefined - there is no reload register. Reaching 00 always enters DONE,
//               and done stays high until the next load or reset.
// -----------------------------------------------------------------------------
module two_dncnt #(
  parameter int CNT_BIT_WIDTH = 4,
  parameter int LIMIT         = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic [CNT_BIT_WIDTH-1:0] ld_val0,
  input  logic [CNT_BIT_WIDTH-1:0] ld_val1,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     tick,
  output logic [CNT_BIT_WIDTH-1:0] out0,
  output logic [CNT_BIT_WIDTH-1:0] out1,
  output logic [1:0]               state,
  output logic                     done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_BIT_WIDTH-1:0] LIM_D  = CNT_BIT_WIDTH'(LIMIT);
  localparam logic [CNT_BIT_WIDTH-1:0] ZERO_D = '0;
  localparam logic [CNT_BIT_WIDTH-1:0] ONE_D  = CNT_BIT_WIDTH'(1);

  // Saturate a preset digit so no out-of-range value reaches the display.
  function automatic logic [CNT_BIT_WIDTH-1:0] clamp_digit(
    input logic [CNT_BIT_WIDTH-1:0] d
  );
    return (d > LIM_D) ? LIM_D : d;
  endfunction

  logic [CNT_BIT_WIDTH-1:0] ld_c0, ld_c1;
  logic [CNT_BIT_WIDTH-1:0] dec0, dec1;
  logic [CNT_BIT_WIDTH-1:0] cnt0_nxt, cnt1_nxt;
  logic [1:0]               state_nxt;
  logic                     done_nxt;
  logic                     cnt_zero, cnt_one;

`ifdef AUTO_RELOAD_EN
  logic [CNT_BIT_WIDTH-1:0] rld0, rld1;
  logic                     rld_zero;
`endif

  assign ld_c0    = clamp_digit(ld_val0);
  assign ld_c1    = clamp_digit(ld_val1);
  assign cnt_zero = (out1 == ZERO_D) && (out0 == ZERO_D);
  assign cnt_one  = (out1 == ZERO_D) && (out0 == ONE_D);

  // One-step decrement with the ones-to-tens borrow.
  always_comb begin
    dec0 = out0;
    dec1 = out1;
    if (out0 == ZERO_D) begin
      dec0 = LIM_D;
      dec1 = out1 - ONE_D;
    end else begin
      dec0 = out0 - ONE_D;
    end
  end

`ifdef AUTO_RELOAD_EN
  assign rld_zero = (rld1 == ZERO_D) && (rld0 == ZERO_D);
`endif

  // Control FSM and next-count selection. Priority is ld, then per-state events.
  always_comb begin
    cnt0_nxt  = out0;
    cnt1_nxt  = out1;
    state_nxt = state;
    done_nxt  = done;
    if (ld) begin
      cnt0_nxt  = ld_c0;
      cnt1_nxt  = ld_c1;
      state_nxt = ST_IDLE;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !cnt_zero) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // done is only a one-cycle pulse while running.
          done_nxt = 1'b0;
          if (pause) begin
            state_nxt = ST_PAUSE;
          end else if (tick && !cnt_zero) begin
            if (cnt_one) begin
`ifdef AUTO_RELOAD_EN
              if (!rld_zero) begin
                cnt0_nxt = rld0;
                cnt1_nxt = rld1;
                done_nxt = 1'b1;
              end else begin
                cnt0_nxt  = ZERO_D;
                cnt1_nxt  = ZERO_D;
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
              end
`else
              cnt0_nxt  = ZERO_D;
              cnt1_nxt  = ZERO_D;
              state_nxt = ST_DONE;
              done_nxt  = 1'b1;
`endif
            end else begin
              cnt0_nxt = dec0;
              cnt1_nxt = dec1;
            end
          end
        end
        ST_PAUSE: begin
          // Resume does not consume a coincident tick.
          if (start) state_nxt = ST_RUN;
        end
        default: begin
          // DONE: count and flag hold until ld or rst.
          state_nxt = ST_DONE;
        end
      endcase
    end
  end

  // State, digit and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0  <= ZERO_D;
      out1  <= ZERO_D;
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      out0  <= cnt0_nxt;
      out1  <= cnt1_nxt;
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

`ifdef AUTO_RELOAD_EN
  // Reload register captures the clamped preset on every load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rld0 <= ZERO_D;
      rld1 <= ZERO_D;
    end else if (ld) begin
      rld0 <= ld_c0;
      rld1 <= ld_c1;
    end
  end
`endif

endmodule

// File: tb/tb_two_dncnt.sv
// -----------------------------------------------------------------------------
// tb_two_dncnt : directed testbench for two_dncnt. It covers both the default
// build and the build with AUTO_RELOAD_EN defined.
// -----------------------------------------------------------------------------
module tb_two_dncnt;

`ifdef AUTO_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic [3:0] ld_val0 = 4'd0;
  logic [3:0] ld_val1 = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] out0, out1;
  logic [1:0] state;
  logic       done;

  int checks = 0;
  int errors = 0;

  two_dncnt #(.CNT_BIT_WIDTH(4), .LIMIT(9)) dut (
    .clk(clk), .rst(rst), .ld(ld), .ld_val0(ld_val0), .ld_val1(ld_val1),
    .start(start), .pause(pause), .tick(tick),
    .out0(out0), .out1(out1), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the displayed digits against a decimal value.
  task automatic check_cnt(input string tag, input int e);
    check(tag, {24'd0, out1, out0}, 32'((e / 10) * 16 + (e % 10)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v1, input logic [3:0] v0);
    ld_val1 = v1;
    ld_val0 = v0;
    ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    int e;
    // Reset dominates a simultaneous load and start.
    ld_val1 = 4'd5; ld_val0 = 4'd5; ld = 1'b1; start = 1'b1; rst = 1'b1;
    step(); step();
    rst = 1'b0; ld = 1'b0; start = 1'b0;
    check_cnt("rst_cnt", 0);
    check("rst_state", 32'(state), ST_IDLE);
    check("rst_done", 32'(done), 0);

    // Full countdown from 23.
    load(4'd2, 4'd3);
    check_cnt("ld23", 23);
    check("ld23_state", 32'(state), ST_IDLE);
    press_start();
    check("start_run", 32'(state), ST_RUN);
    for (int i = 1; i <= 23; i++) begin
      tick_once();
      e = (i == 23 && RL) ? 23 : 23 - i;
      check_cnt($sformatf("cd_cnt_%0d", i), e);
      check($sformatf("cd_state_%0d", i), 32'(state),
            (i == 23 && !RL) ? ST_DONE : ST_RUN);
      check($sformatf("cd_done_%0d", i), 32'(done), (i == 23) ? 1 : 0);
      step(); step();
    end
    check("done_hold", 32'(done), RL ? 0 : 1);
    tick_once();
    check_cnt("tick24_cnt", RL ? 22 : 0);
    check("tick24_state", 32'(state), RL ? ST_RUN : ST_DONE);

    // Pause and resume.
    load(4'd1, 4'd0);
    press_start();
    tick_once(); check_cnt("pr_09", 9);
    tick_once(); check_cnt("pr_08", 8);
    pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
    check_cnt("pause_tick", 8);
    check("pause_state", 32'(state), ST_PAUSE);
    tick_once();
    check_cnt("paused_tick", 8);
    check("paused_state", 32'(state), ST_PAUSE);
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    check_cnt("resume_tick", 8);
    check("resume_state", 32'(state), ST_RUN);
    tick_once();
    check_cnt("resume_07", 7);

    // Clamp on load, and load priority over start.
    ld_val1 = 4'hC; ld_val0 = 4'hF; ld = 1'b1; start = 1'b1;
    step();
    ld = 1'b0; start = 1'b0;
    check_cnt("clamp99", 99);
    check("clamp_state", 32'(state), ST_IDLE);
    tick_once();
    check_cnt("idle_tick", 99);
    load(4'd0, 4'd0);
    press_start();
    check("start_zero_state", 32'(state), ST_IDLE);
    check("start_zero_done", 32'(done), 0);

    // Load mid-run beats a coincident tick.
    load(4'd1, 4'd5);
    press_start();
    check_cnt("run15", 15);
    ld_val1 = 4'd0; ld_val0 = 4'd4; ld = 1'b1; tick = 1'b1;
    step();
    ld = 1'b0; tick = 1'b0;
    check_cnt("ld_mid_run", 4);
    check("ld_mid_state", 32'(state), ST_IDLE);
    press_start();
    tick_once(); check_cnt("r_03", 3);
    tick_once(); check_cnt("r_02", 2);
    tick_once(); check_cnt("r_01", 1);
    tick_once();
    check_cnt("r_end", RL ? 4 : 0);
    check("r_end_state", 32'(state), RL ? ST_RUN : ST_DONE);
    check("r_end_done", 32'(done), 1);
    press_start();
    check("end_start_state", 32'(state), RL ? ST_RUN : ST_DONE);
    check("end_start_done", 32'(done), RL ? 0 : 1);
    load(4'd3, 4'd0);
    check_cnt("ld30", 30);
    check("ld30_state", 32'(state), ST_IDLE);
    check("ld30_done", 32'(done), 0);

`ifdef AUTO_RELOAD_EN
    // Auto-reload from 02.
    load(4'd0, 4'd2);
    press_start();
    tick_once();
    check_cnt("ar_01", 1);
    check("ar_01_done", 32'(done), 0);
    tick_once();
    check_cnt("ar_02", 2);
    check("ar_state", 32'(state), ST_RUN);
    check("ar_done_pulse", 32'(done), 1);
    step();
    check("ar_done_clear", 32'(done), 0);
    load(4'd0, 4'd0);
    press_start();
    check("ar_zero_idle", 32'(state), ST_IDLE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
